// File: rtl/rca_nibble_seq_arb_pkg.sv
// ---------------------------------------------------------------------------
// rca_nibble_seq_arb_pkg : shared FSM states and nibble sizing.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rca_nibble_seq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rca_4b.sv
// ---------------------------------------------------------------------------
// rca_4b : 4-bit ripple-carry adder slice.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rca_4b
  import rca_nibble_seq_arb_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];

endmodule

`default_nettype wire

// File: rtl/rca_nibble_seq_arb.sv
// ---------------------------------------------------------------------------
// rca_nibble_seq_arb : round-robin nibble-serial adder sharing one rca_4b.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rca_nibble_seq_arb
  import rca_nibble_seq_arb_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);

  localparam int NIB    = nib_count(WIDTH);
  localparam int IDX_W  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int NIB_SH = $clog2(NIBBLE_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
    $error("rca_nibble_seq_arb: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t                    state;
  state_t                    state_nxt;
  logic [WIDTH-1:0]          a_reg;
  logic [WIDTH-1:0]          b_reg;
  logic [WIDTH-1:0]          sum_reg;
  logic                      carry;
  logic                      cout_reg;
  logic                      id_reg;
  logic                      last_grant;
  logic [IDX_W-1:0]          nib_idx;
  logic [IDX_W+NIB_SH-1:0]   nib_base;
  logic                      grant_valid;
  logic                      grant_id;
  logic                      accept;
  logic                      last_nib;
  logic [NIBBLE_W-1:0]       s_nib;
  logic                      c_out;

  // Round-robin only matters on contention; a lone requester always wins.
  assign grant_valid = (state == IDLE) && (req0_valid || req1_valid);
  assign grant_id    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready  = rst_n && grant_valid && !grant_id;
  assign req1_ready  = rst_n && grant_valid &&  grant_id;
  assign accept      = req0_ready | req1_ready;

  assign nib_base = {nib_idx, {NIB_SH{1'b0}}};
  assign last_nib = (nib_idx == LAST_IDX);

  rca_4b u_rca (
    .a    (a_reg[nib_base +: NIBBLE_W]),
    .b    (b_reg[nib_base +: NIBBLE_W]),
    .cin  (carry),
    .sum  (s_nib),
    .cout (c_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_nib) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
      carry      <= 1'b0;
      cout_reg   <= 1'b0;
      id_reg     <= 1'b0;
      last_grant <= 1'b1;
      nib_idx    <= '0;
    end else if (accept) begin
      a_reg      <= grant_id ? req1_a   : req0_a;
      b_reg      <= grant_id ? req1_b   : req0_b;
      carry      <= grant_id ? req1_cin : req0_cin;
      id_reg     <= grant_id;
      last_grant <= grant_id;
      nib_idx    <= '0;
    end else if (state == RUN) begin
      sum_reg[nib_base +: NIBBLE_W] <= s_nib;
      carry   <= c_out;
      nib_idx <= last_nib ? '0 : nib_idx + 1'b1;
      if (last_nib) cout_reg <= c_out;
    end
  end

  assign rsp_id   = id_reg;
  assign rsp_sum  = sum_reg;
  assign rsp_cout = cout_reg;

endmodule

`default_nettype wire

// File: tb/tb_rca_nibble_seq_arb.sv
// ---------------------------------------------------------------------------
// tb_rca_nibble_seq_arb : scoreboard bench for 16-bit and 32-bit instances.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rca_nibble_seq_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v0, v1, r0, r1, c0, c1;
  logic [15:0] a0, b0, a1, b1, rsp_sum;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;

  logic        wv0, wv1, wr0, wr1, wc0, wc1;
  logic [31:0] wa0, wb0, wa1, wb1, w_rsp_sum;
  logic        w_rsp_valid, w_rsp_ready, w_rsp_id, w_rsp_cout, w_busy;

  rca_nibble_seq_arb #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0), .req0_cin(c0),
    .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1), .req1_cin(c1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
  );

  rca_nibble_seq_arb #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(wv0), .req0_ready(wr0), .req0_a(wa0), .req0_b(wb0), .req0_cin(wc0),
    .req1_valid(wv1), .req1_ready(wr1), .req1_a(wa1), .req1_b(wb1), .req1_cin(wc1),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_id(w_rsp_id),
    .rsp_sum(w_rsp_sum), .rsp_cout(w_rsp_cout), .busy(w_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        id;
    logic [15:0] sum;
    logic        cout;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  exp_t        mon_h;
  logic [16:0] mon_t;
  logic        prev_valid = 1'b0;

  function automatic logic [16:0] ref_add16(input logic [15:0] a, input logic [15:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {16'd0, c};
  endfunction

  function automatic logic [32:0] ref_add32(input logic [31:0] a, input logic [31:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Expected results are queued on the accept edge and retired on the response handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (v0 && r0) begin
        mon_t = ref_add16(a0, b0, c0);
        mon_e.id = 1'b0; mon_e.sum = mon_t[15:0]; mon_e.cout = mon_t[16]; mon_e.acc = cyc + 1;
        sb.push_back(mon_e);
      end
      if (v1 && r1) begin
        mon_t = ref_add16(a1, b1, c1);
        mon_e.id = 1'b1; mon_e.sum = mon_t[15:0]; mon_e.cout = mon_t[16]; mon_e.acc = cyc + 1;
        sb.push_back(mon_e);
      end
      checks++;
      if (r0 && r1) begin
        errors++;
        $display("FAIL both_ready: r0=%b r1=%b, expected at most one", r0, r1);
      end
      if (rsp_valid && !prev_valid && sb.size() != 0) begin
        checks++;
        if (cyc - sb[0].acc !== 4) begin
          errors++;
          $display("FAIL latency: got %0d cycles, expected 4", cyc - sb[0].acc);
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: id=%b sum=%h cout=%b with empty scoreboard", rsp_id, rsp_sum, rsp_cout);
        end else begin
          mon_h = sb.pop_front();
          if ({rsp_id, rsp_cout, rsp_sum} !== {mon_h.id, mon_h.cout, mon_h.sum}) begin
            errors++;
            $display("FAIL rsp: got id=%b cout=%b sum=%h, expected id=%b cout=%b sum=%h",
                     rsp_id, rsp_cout, rsp_sum, mon_h.id, mon_h.cout, mon_h.sum);
          end
        end
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send16(input logic id, input logic [15:0] a, input logic [15:0] b, input logic cin);
    bit done = 1'b0;
    if (id) begin v1 = 1'b1; a1 = a; b1 = b; c1 = cin; end
    else    begin v0 = 1'b1; a0 = a; b0 = b; c0 = cin; end
    #1;
    for (int i = 0; i < 100 && !done; i++) begin
      if ((id ? r1 : r0) === 1'b1) done = 1'b1;
      tick();
    end
    // Scramble the bus after acceptance; the latched operands must not change.
    if (id) begin v1 = 1'b0; a1 = 16'($urandom); b1 = 16'($urandom); c1 = 1'($urandom); end
    else    begin v0 = 1'b0; a0 = 16'($urandom); b0 = 16'($urandom); c0 = 1'($urandom); end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: requester %0d never accepted, expected ready", id);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1; wv0 = 1'b1; wv1 = 1'b1;
    rsp_ready = 1'b1; w_rsp_ready = 1'b1;
    repeat (2) tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL rst_rsp_id: got %b expected 0", rsp_id); end
    checks++; if (rsp_sum !== 16'h0000) begin errors++; $display("FAIL rst_rsp_sum: got %h expected 0000", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL rst_rsp_cout: got %b expected 0", rsp_cout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if ({r1, r0} !== 2'b00) begin errors++; $display("FAIL rst_readies: got %b%b expected 00", r1, r0); end
    checks++; if ({wr1, wr0, w_rsp_valid, w_busy} !== 4'b0000) begin
      errors++; $display("FAIL rst_wide: got rdy=%b%b valid=%b busy=%b expected all 0", wr1, wr0, w_rsp_valid, w_busy);
    end
    v0 = 1'b0; v1 = 1'b0; wv0 = 1'b0; wv1 = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_contention();
    logic exp_g = 1'b0;
    int   got   = 0;
    int   n     = 0;
    rsp_ready = 1'b1;
    a0 = 16'h1111; b0 = 16'h2222; c0 = 1'b0;
    a1 = 16'hF00D; b1 = 16'h0FF3; c1 = 1'b1;
    v0 = 1'b1; v1 = 1'b1;
    #1;
    while (got < 4 && n < 200) begin
      if (r0 || r1) begin
        checks++;
        if (r1 !== exp_g) begin
          errors++;
          $display("FAIL grant_order: got requester %b expected %b at grant %0d", r1, exp_g, got);
        end
        tick();
        if (exp_g) begin a1 = 16'($urandom); b1 = 16'($urandom); c1 = 1'($urandom); end
        else       begin a0 = 16'($urandom); b0 = 16'($urandom); c0 = 1'($urandom); end
        exp_g = ~exp_g;
        got++;
      end else begin
        tick();
      end
      n++;
    end
    checks++;
    if (got != 4) begin errors++; $display("FAIL contention_timeout: got %0d grants expected 4", got); end
    v0 = 1'b0; v1 = 1'b0;
    wait_drain();
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    send16(1'b0, 16'h1234, 16'h4321, 1'b0);
    wait_drain();
  endtask

  task automatic test_full_carry();
    rsp_ready = 1'b1;
    send16(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    send16(1'b1, 16'h8000, 16'h8000, 1'b0);
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [16:0] e;
    int          n = 0;
    rsp_ready = 1'b0;
    send16(1'b0, 16'hABCD, 16'h1357, 1'b1);
    e = ref_add16(16'hABCD, 16'h1357, 1'b1);
    a0 = 16'h0101; b0 = 16'h0202; c0 = 1'b0;
    a1 = 16'h7FFF; b1 = 16'h0001; c1 = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    checks++;
    if (!rsp_valid) begin errors++; $display("FAIL bp_timeout: rsp_valid=%b expected 1", rsp_valid); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, 1'b0, e[16], e[15:0]}) begin
        errors++;
        $display("FAIL bp_hold: got valid=%b id=%b cout=%b sum=%h expected 1 0 %b %h",
                 rsp_valid, rsp_id, rsp_cout, rsp_sum, e[16], e[15:0]);
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b expected 1", busy); end
      checks++;
      if ({r1, r0} !== 2'b00) begin errors++; $display("FAIL bp_readies: got %b%b expected 00", r1, r0); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: rsp_valid=%b expected 0", rsp_valid); end
    checks++;
    if ({r1, r0} !== 2'b10) begin errors++; $display("FAIL bp_next_grant: got %b%b expected 10", r1, r0); end
    tick();
    v0 = 1'b0; v1 = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    rsp_ready = 1'b1;
    send16(1'b0, 16'h0F0F, 16'h00F1, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL mid_rst_flags: valid=%b busy=%b expected 00", rsp_valid, busy); end
    checks++;
    if (rsp_sum !== 16'h0000) begin errors++; $display("FAIL mid_rst_sum: got %h expected 0000", rsp_sum); end
    checks++;
    if ({rsp_id, rsp_cout} !== 2'b00) begin errors++; $display("FAIL mid_rst_id_cout: got %b%b expected 00", rsp_id, rsp_cout); end
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL stale_rsp: rsp_valid seen %0d cycles expected 0", seen); end
    send16(1'b0, 16'h0001, 16'h0001, 1'b0);
    wait_drain();
  endtask

  task automatic test_wide_random();
    logic        lg = 1'b1;
    logic        g;
    logic [1:0]  sel;
    logic [32:0] e;
    int          lat;
    w_rsp_ready = 1'b1;
    for (int op = 0; op < 1000; op++) begin
      sel = 2'($urandom_range(1, 3));
      wa0 = $urandom; wb0 = $urandom; wc0 = 1'($urandom);
      wa1 = $urandom; wb1 = $urandom; wc1 = 1'($urandom);
      wv0 = sel[0]; wv1 = sel[1];
      g = (sel == 2'b11) ? ~lg : sel[1];
      e = g ? ref_add32(wa1, wb1, wc1) : ref_add32(wa0, wb0, wc0);
      #1;
      checks++;
      if ({wr1, wr0} !== (g ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL w_grant: op %0d got %b%b expected grant %b", op, wr1, wr0, g);
      end
      tick();
      lg = g;
      wv0 = 1'b0; wv1 = 1'b0;
      wa0 = $urandom; wb0 = $urandom; wa1 = $urandom; wb1 = $urandom;
      lat = 0;
      while (!w_rsp_valid && lat < 20) begin tick(); lat++; end
      checks++;
      if (lat !== 8) begin errors++; $display("FAIL w_latency: op %0d got %0d expected 8", op, lat); end
      checks++;
      if ({w_rsp_id, w_rsp_cout, w_rsp_sum} !== {g, e[32], e[31:0]}) begin
        errors++;
        $display("FAIL w_rsp: op %0d got id=%b cout=%b sum=%h expected id=%b cout=%b sum=%h",
                 op, w_rsp_id, w_rsp_cout, w_rsp_sum, g, e[32], e[31:0]);
      end
      tick();
      checks++;
      if (w_busy !== 1'b0) begin errors++; $display("FAIL w_idle: op %0d busy=%b expected 0", op, w_busy); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0; c0 = 1'b0; c1 = 1'b0;
    wv0 = 1'b0; wv1 = 1'b0; wa0 = '0; wb0 = '0; wa1 = '0; wb1 = '0; wc0 = 1'b0; wc1 = 1'b0;
    rsp_ready = 1'b0; w_rsp_ready = 1'b0;
    test_reset();
    test_contention();
    test_single();
    test_full_carry();
    test_backpressure();
    test_reset_mid_run();
    test_wide_random();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL leftover: %0d results never returned, expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
